dac_pattern_sequencer: RTL and testbench
========================================

Name: dac_pattern_sequencer

Overview:
- Schedules the DAC sample stream as bursts of samples separated by gaps.
- Per run, selects the burst sample source: upstream tone generator, upstream host stream, internal PRBS32, or a constant word.
- Sits between the pattern sources and the DAC serializer.
- Presents a single valid/ready stream with one registered output stage.

Parameters:
DATA_W, 32, sample width
CNT_W, 16, width of burst-length, gap-length and repeat counters
GAP_WORD, 32'h0000_0000, data driven during gap beats
PRBS_SEED, 32'hFFFF_FFFF, PRBS load value at reset and at each start

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_src_sel  in  2  0=src0 (tone), 1=src1 (host), 2=PRBS, 3=constant
cfg_const  in  DATA_W  constant word for source 3
cfg_burst_len  in  CNT_W  samples per burst
cfg_gap_len  in  CNT_W  gap beats between bursts
cfg_num_bursts  in  CNT_W  bursts per run; 0=infinite
start  in  1  single-cycle run request
stop  in  1  single-cycle abort
s0_data  in  DATA_W  tone stream data
s0_valid  in  1  tone stream valid
s0_ready  out  1  tone stream ready
s1_data  in  DATA_W  host stream data
s1_valid  in  1  host stream valid
s1_ready  out  1  host stream ready
o_data  out  DATA_W  sample to DAC
o_valid  out  1  output valid
o_ready  in  1  DAC ready
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse when a run completes or is aborted
burst_idx  out  CNT_W  bursts completed in the current run

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, o_valid=0, o_data=0, s0_ready=0, s1_ready=0, busy=0, done=0, burst_idx=0, PRBS register=PRBS_SEED.
- Output register:
  - Loads when load_en = ~o_valid | o_ready.
  - o_valid falls only when the held beat has been accepted and nothing new loads.
  - o_data and o_valid are never changed while o_valid=1 and o_ready=0.
- Configuration is latched on an accepted start. Configuration inputs are ignored while busy.
- FSM:
  - IDLE: start with cfg_burst_len!=0 -> latch cfg, reseed PRBS, clear counters, go to BURST.
    - start with cfg_burst_len==0 is ignored; no state change and no done.
  - BURST: one sample is loaded per cycle in which load_en=1 and the source is available.
    - Sources 2 and 3 are always available.
    - Sources 0 and 1 require sX_valid.
    - sX_ready = (state==BURST) & (sel==X) & load_en. It is combinational, with no dependence on sX_valid.
    - After the burst_len-th sample loads: burst_idx increments.
    - Then, if num_bursts!=0 and burst_idx+1==num_bursts -> DONE.
    - Else if gap_len!=0 -> GAP.
    - Else -> BURST, starting a new burst on the next cycle with no bubble.
  - GAP: loads GAP_WORD on each cycle with load_en. After gap_len beats load -> BURST.
  - DONE: pulses done for one cycle, then goes to IDLE.
    - The output register keeps its final beat until it is accepted.
- PRBS:
  - 32-bit Fibonacci LFSR.
  - next = {q[30:0], q[31]^q[29]^q[25]^q[24]}.
  - The first sample is the seed. The LFSR advances only when a PRBS sample loads.
  - It continues across bursts and reseeds on each start.
- stop: takes priority over every transition.
  - From BURST, GAP or DONE -> IDLE next cycle, with a done pulse in that cycle.
  - Source readies go low immediately.
  - A pending output beat is held until accepted and is not dropped.
  - stop in IDLE has no effect.
- start while busy is ignored. If start and stop arrive in the same cycle in IDLE, stop wins.
- Counters wrap at 2^CNT_W. In infinite mode, burst_idx wraps to 0.
- rst mid-run: synchronous return to the reset values on the next edge. A pending beat is discarded.

Test Plan:
- PRBS, burst_len=3, gap_len=2, num_bursts=2, o_ready=1 -> o_data FFFFFFFF, FFFFFFFE, FFFFFFFC, 0, 0, next three PRBS words; done pulses once; burst_idx=2.
- Constant AABBCCDD, burst_len=4, gap_len=0, num_bursts=3 -> 12 consecutive AABBCCDD beats with no bubbles, then done; busy=0 afterwards.
- src0 with s0_valid toggling every cycle, burst_len=5 -> exactly 5 samples pass in order; s1_ready stays 0; no beat duplicated or lost.
- o_ready held low 4 cycles mid-burst -> o_data/o_valid stable throughout; sX_ready=0; sequence resumes with no skip.
- Infinite mode, stop asserted mid-GAP while o_ready=0 -> IDLE next cycle, done pulse, held beat stays valid until o_ready, then o_valid=0.
- start with burst_len=0 -> busy stays 0, no done; rst asserted mid-BURST -> all outputs at reset values after one edge.

Source files
------------

// File: rtl/dac_pattern_sequencer.sv
// Burst/gap scheduler for the DAC sample stream: picks a per-run sample source
// and presents it through a single registered valid/ready output stage.
//
// state | meaning
// IDLE  | waiting for start; output stage drains any held beat
// BURST | loading samples from the selected source
// GAP   | loading GAP_WORD between bursts
// DONE  | run finished; done pulses for this one cycle
module dac_pattern_sequencer #(
   parameter int                DATA_W    = 32,
   parameter int                CNT_W     = 16,
   parameter logic [DATA_W-1:0] GAP_WORD  = 32'h0000_0000,
   parameter logic [31:0]       PRBS_SEED = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cfg_src_sel,
   input  logic [DATA_W-1:0] cfg_const,
   input  logic [CNT_W-1:0]  cfg_burst_len,
   input  logic [CNT_W-1:0]  cfg_gap_len,
   input  logic [CNT_W-1:0]  cfg_num_bursts,
   input  logic              start,
   input  logic              stop,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_valid,
   output logic              s1_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  burst_idx
);

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP, ST_DONE} state_t;

   state_t            state;
   logic [1:0]        sel_q;
   logic [DATA_W-1:0] const_q;
   logic [CNT_W-1:0]  blen_q;
   logic [CNT_W-1:0]  glen_q;
   logic [CNT_W-1:0]  nb_q;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       prbs_q;
   logic [31:0]       prbs_nxt;
   logic [CNT_W-1:0]  idx_inc;
   logic [DATA_W-1:0] smp_data;
   logic              load_en;
   logic              src_avail;
   logic              load_smp;
   logic              load_gap;
   logic              cnt_last;

   assign load_en  = ~o_valid | o_ready;
   assign s0_ready = (state == ST_BURST) & (sel_q == 2'd0) & load_en & ~stop;
   assign s1_ready = (state == ST_BURST) & (sel_q == 2'd1) & load_en & ~stop;
   assign busy     = (state != ST_IDLE);
   assign prbs_nxt = {prbs_q[30:0], prbs_q[31] ^ prbs_q[29] ^ prbs_q[25] ^ prbs_q[24]};
   assign idx_inc  = burst_idx + CNT_W'(1);
   assign cnt_last = (cnt == CNT_W'(1));

   always_comb begin
      src_avail = 1'b1;
      smp_data  = const_q;
      case (sel_q)
         2'd0:    begin src_avail = s0_valid; smp_data = s0_data; end
         2'd1:    begin src_avail = s1_valid; smp_data = s1_data; end
         2'd2:    smp_data = DATA_W'(prbs_q);
         default: smp_data = const_q;
      endcase
   end

   assign load_smp = (state == ST_BURST) & load_en & src_avail & ~stop;
   assign load_gap = (state == ST_GAP) & load_en & ~stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         o_valid   <= 1'b0;
         o_data    <= '0;
         done      <= 1'b0;
         burst_idx <= '0;
         prbs_q    <= PRBS_SEED;
         cnt       <= '0;
         sel_q     <= '0;
         const_q   <= '0;
         blen_q    <= '0;
         glen_q    <= '0;
         nb_q      <= '0;
      end else begin
         done <= 1'b0;

         if (load_smp || load_gap) begin
            o_valid <= 1'b1;
            o_data  <= load_smp ? smp_data : GAP_WORD;
         end else if (o_ready) begin
            o_valid <= 1'b0;
         end

         if (load_smp && sel_q == 2'd2)
            prbs_q <= prbs_nxt;

         // a stop in DONE must not stretch the pulse already in flight
         if (stop && state != ST_IDLE) begin
            state <= ST_IDLE;
            done  <= (state != ST_DONE);
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !stop && cfg_burst_len != '0) begin
                     sel_q     <= cfg_src_sel;
                     const_q   <= cfg_const;
                     blen_q    <= cfg_burst_len;
                     glen_q    <= cfg_gap_len;
                     nb_q      <= cfg_num_bursts;
                     prbs_q    <= PRBS_SEED;
                     cnt       <= cfg_burst_len;
                     burst_idx <= '0;
                     state     <= ST_BURST;
                  end
               end
               ST_BURST: begin
                  if (load_smp) begin
                     if (cnt_last) begin
                        burst_idx <= idx_inc;
                        if (nb_q != '0 && idx_inc == nb_q) begin
                           state <= ST_DONE;
                           done  <= 1'b1;
                        end else if (glen_q != '0) begin
                           state <= ST_GAP;
                           cnt   <= glen_q;
                        end else begin
                           cnt <= blen_q;
                        end
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
               end
               ST_GAP: begin
                  if (load_gap) begin
                     if (cnt_last) begin
                        state <= ST_BURST;
                        cnt   <= blen_q;
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dac_pattern_sequencer.sv
// Directed bench for dac_pattern_sequencer: table of pattern runs plus
// hand-written sequences for source handshakes, stalls, stop and reset.
module tb_dac_pattern_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cfg_src_sel;
   logic [31:0] cfg_const;
   logic [15:0] cfg_burst_len, cfg_gap_len, cfg_num_bursts;
   logic        start, stop;
   logic [31:0] s0_data, s1_data, o_data;
   logic        s0_valid, s0_ready, s1_valid, s1_ready;
   logic        o_valid, o_ready, busy, done;
   logic [15:0] burst_idx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [31:0] beat_q[$];
   int          cyc_q[$];

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] cnst;
      int          blen;
      int          glen;
      int          nb;
      int          exp_n;
      int          exp_idx;
   } vec_t;

   vec_t vecs[5];

   dac_pattern_sequencer dut (
      .clk(clk), .rst(rst),
      .cfg_src_sel(cfg_src_sel), .cfg_const(cfg_const),
      .cfg_burst_len(cfg_burst_len), .cfg_gap_len(cfg_gap_len),
      .cfg_num_bursts(cfg_num_bursts),
      .start(start), .stop(stop),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
      .busy(busy), .done(done), .burst_idx(burst_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // beat is accepted on the next rising edge when valid&ready here
   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid && o_ready) begin
            beat_q.push_back(o_data);
            cyc_q.push_back(cyc);
         end
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench timeout");
   end

   function automatic logic [31:0] lfsr(input logic [31:0] q);
      return {q[30:0], q[31] ^ q[29] ^ q[25] ^ q[24]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int db, qb, last;
      logic [31:0] exp_q[$];
      logic [31:0] p;
      db = done_cnt;
      qb = beat_q.size();
      cfg_src_sel    = v.sel;
      cfg_const      = v.cnst;
      cfg_burst_len  = 16'(v.blen);
      cfg_gap_len    = 16'(v.glen);
      cfg_num_bursts = 16'(v.nb);
      pulse_start();
      // config changes and a second start while busy must be ignored
      cfg_src_sel    = ~v.sel;
      cfg_const      = ~v.cnst;
      cfg_burst_len  = 16'd9;
      cfg_gap_len    = 16'd5;
      cfg_num_bursts = 16'd0;
      pulse_start();
      for (int c = 0; c < 600 && done_cnt == db; c++) tick(1);
      tick(3);
      p = 32'hFFFF_FFFF;
      for (int b = 0; b < v.nb; b++) begin
         for (int s = 0; s < v.blen; s++) begin
            exp_q.push_back(v.sel == 2'd2 ? p : v.cnst);
            if (v.sel == 2'd2) p = lfsr(p);
         end
         if (b < v.nb - 1)
            for (int g = 0; g < v.glen; g++) exp_q.push_back(32'h0);
      end
      chk($sformatf("vec%0d_beat_count", id), 32'(beat_q.size() - qb), 32'(v.exp_n));
      for (int i = 0; i < exp_q.size() && qb + i < beat_q.size(); i++)
         chk($sformatf("vec%0d_beat%0d", id, i), beat_q[qb + i], exp_q[i]);
      if (beat_q.size() > qb) begin
         last = cyc_q.size() - 1;
         chk($sformatf("vec%0d_no_bubble", id), 32'(cyc_q[last] - cyc_q[qb]), 32'(v.exp_n - 1));
      end
      chk($sformatf("vec%0d_done_pulses", id), 32'(done_cnt - db), 32'd1);
      chk($sformatf("vec%0d_burst_idx", id), 32'(burst_idx), 32'(v.exp_idx));
      chk($sformatf("vec%0d_busy_after", id), 32'(busy), 32'd0);
   endtask

   task automatic stream_run(input string name, input logic [1:0] sel, input int blen,
                             input bit tog, input int stall_at, input logic [31:0] base);
      int db, qb, stall_left, bad_other, bad_hold;
      bit stalled;
      logic take;
      logic [31:0] hold_d;
      db = done_cnt;
      qb = beat_q.size();
      bad_other = 0;
      bad_hold = 0;
      stall_left = 0;
      stalled = 1'b0;
      hold_d = '0;
      s0_data = base;
      s1_data = base;
      s0_valid = (sel == 2'd0);
      s1_valid = (sel == 2'd1);
      cfg_src_sel    = sel;
      cfg_const      = 32'hDEAD_BEEF;
      cfg_burst_len  = 16'(blen);
      cfg_gap_len    = 16'd0;
      cfg_num_bursts = 16'd1;
      pulse_start();
      for (int c = 0; c < 300 && done_cnt == db; c++) begin
         @(negedge clk);
         take = (sel == 2'd0) ? (s0_valid & s0_ready) : (s1_valid & s1_ready);
         if ((sel == 2'd0) ? s1_ready : s0_ready) bad_other++;
         if (stall_left > 0 && (o_valid !== 1'b1 || o_data !== hold_d || s0_ready || s1_ready))
            bad_hold++;
         @(posedge clk);
         #1;
         if (take) begin
            if (sel == 2'd0) s0_data = s0_data + 1;
            else             s1_data = s1_data + 1;
         end
         if (tog) begin
            if (sel == 2'd0) s0_valid = ~s0_valid;
            else             s1_valid = ~s1_valid;
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) o_ready = 1'b1;
         end else if (!stalled && stall_at > 0 && beat_q.size() - qb >= stall_at) begin
            o_ready = 1'b0;
            stall_left = 4;
            stalled = 1'b1;
            hold_d = o_data;
         end
      end
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      o_ready = 1'b1;
      tick(3);
      chk({name, "_beat_count"}, 32'(beat_q.size() - qb), 32'(blen));
      for (int i = 0; i < blen && qb + i < beat_q.size(); i++)
         chk($sformatf("%s_beat%0d", name, i), beat_q[qb + i], base + 32'(i));
      chk({name, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
      chk({name, "_other_ready"}, 32'(bad_other), 32'd0);
      if (stall_at > 0) begin
         chk({name, "_stall_seen"}, 32'(stalled), 32'd1);
         chk({name, "_stall_hold"}, 32'(bad_hold), 32'd0);
      end
   endtask

   initial begin
      int db;
      vecs[0] = '{2'd2, 32'h0000_0000, 3, 2, 2, 8, 2};
      vecs[1] = '{2'd3, 32'hAABB_CCDD, 4, 0, 3, 12, 3};
      vecs[2] = '{2'd3, 32'h1234_5678, 1, 1, 1, 1, 1};
      vecs[3] = '{2'd2, 32'h0000_0000, 2, 0, 2, 4, 2};
      vecs[4] = '{2'd3, 32'h5A5A_5A5A, 2, 3, 2, 7, 2};

      rst = 1'b1;
      cfg_src_sel = '0; cfg_const = '0;
      cfg_burst_len = '0; cfg_gap_len = '0; cfg_num_bursts = '0;
      start = 1'b0; stop = 1'b0;
      s0_data = '0; s0_valid = 1'b0; s1_data = '0; s1_valid = 1'b0;
      o_ready = 1'b1;
      tick(3);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data", o_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_burst_idx", 32'(burst_idx), 32'd0);
      chk("rst_s0_ready", 32'(s0_ready), 32'd0);
      chk("rst_s1_ready", 32'(s1_ready), 32'd0);
      rst = 1'b0;
      tick(2);

      foreach (vecs[i]) run_vec(vecs[i], i);

      stream_run("src0_toggle", 2'd0, 5, 1'b1, 0, 32'd100);
      stream_run("src1_stall", 2'd1, 6, 1'b0, 2, 32'd200);

      // infinite run, stop in GAP while the DAC is stalled
      db = done_cnt;
      cfg_src_sel = 2'd3; cfg_const = 32'hC0FF_EE00;
      cfg_burst_len = 16'd2; cfg_gap_len = 16'd3; cfg_num_bursts = 16'd0;
      pulse_start();
      tick(3);
      chk("stop_pre_gap_data", o_data, 32'h0);
      o_ready = 1'b0;
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd1);
      chk("stop_hold_valid", 32'(o_valid), 32'd1);
      chk("stop_hold_data", o_data, 32'h0);
      chk("stop_burst_idx", 32'(burst_idx), 32'd1);
      tick(1);
      chk("stop_done_one_cycle", 32'(done), 32'd0);
      tick(2);
      chk("stop_hold_valid_late", 32'(o_valid), 32'd1);
      o_ready = 1'b1;
      tick(1);
      chk("stop_drained", 32'(o_valid), 32'd0);
      chk("stop_done_total", 32'(done_cnt - db), 32'd1);

      // start and stop together in IDLE: stop wins
      cfg_burst_len = 16'd4;
      start = 1'b1; stop = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b0;
      tick(1);
      chk("start_stop_idle_busy", 32'(busy), 32'd0);

      // zero burst length is ignored
      db = done_cnt;
      cfg_burst_len = 16'd0;
      pulse_start();
      tick(3);
      chk("zero_len_busy", 32'(busy), 32'd0);
      chk("zero_len_no_done", 32'(done_cnt - db), 32'd0);

      // reset mid-burst with a pending beat
      cfg_src_sel = 2'd2; cfg_burst_len = 16'd2; cfg_gap_len = 16'd0; cfg_num_bursts = 16'd0;
      pulse_start();
      tick(5);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      o_ready = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
      chk("mid_rst_o_data", o_data, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_burst_idx", 32'(burst_idx), 32'd0);
      chk("mid_rst_s_ready", 32'({s0_ready, s1_ready}), 32'd0);
      rst = 1'b0;
      o_ready = 1'b1;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
